// File: rtl/range_frame_sequencer.sv
// Framing front end for the range finder: registers a valid/ready sample stream and
// drives data_out/go/finish per fixed-length frame, then idles GAP cycles.
// Optional stall timeout that terminates a frame early: define RFS_TIMEOUT_EN.
module range_frame_sequencer #(
  parameter int WIDTH     = 12,
  parameter int FRAME_LEN = 16,
  parameter int GAP       = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic [7:0]       frame_count,
  output logic             truncated
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [7:0] FRAME_LAST = 8'(FRAME_LEN - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);

  if (FRAME_LEN < 2 || FRAME_LEN > 255 || GAP < 1 || GAP > 15 ||
      TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("range_frame_sequencer: parameter outside its legal range");
  end

  state_t     state;
  logic [7:0] sample_cnt;
  logic [3:0] gap_cnt;
  logic       xfer;

  // Ready depends on the registered state only, so a source may legally
  // wait for in_ready before raising in_valid without forming a loop.
  assign in_ready = (state != DRAIN);
  assign xfer     = in_valid && in_ready;

`ifdef RFS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] stall_cnt;
  logic       truncated_q;

  assign truncated = truncated_q;
`else
  assign truncated = 1'b0;
`endif

  // NOTE: every register in this block uses non-blocking assignment so all of
  // them update together from the same pre-edge values, whatever the order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      gap_cnt     <= '0;
      data_out    <= '0;
      go          <= 1'b0;
      finish      <= 1'b0;
      frame_count <= '0;
`ifdef RFS_TIMEOUT_EN
      stall_cnt   <= '0;
      truncated_q <= 1'b0;
`endif
    end else begin
      go     <= 1'b0;
      finish <= 1'b0;
`ifdef RFS_TIMEOUT_EN
      truncated_q <= 1'b0;
`endif

      // During a stall data_out keeps the last sample, which cannot move the
      // range finder's min or max.
      if (xfer) begin
        data_out <= in_data;
      end

      unique case (state)
        IDLE: begin
          if (xfer) begin
            sample_cnt <= 8'd1;
            go         <= 1'b1;
            state      <= RUN;
`ifdef RFS_TIMEOUT_EN
            stall_cnt  <= '0;
`endif
          end
        end

        RUN: begin
          if (xfer) begin
`ifdef RFS_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (sample_cnt == FRAME_LAST) begin
              finish      <= 1'b1;
              frame_count <= frame_count + 8'd1;
              sample_cnt  <= '0;
              gap_cnt     <= GAP_LAST;
              state       <= DRAIN;
            end else begin
              sample_cnt <= sample_cnt + 8'd1;
            end
          end
`ifdef RFS_TIMEOUT_EN
          // A transfer on the same edge wins over the timeout (branch above).
          else if (stall_cnt == TIMEOUT_LAST) begin
            finish      <= 1'b1;
            truncated_q <= 1'b1;
            frame_count <= frame_count + 8'd1;
            sample_cnt  <= '0;
            stall_cnt   <= '0;
            gap_cnt     <= GAP_LAST;
            state       <= DRAIN;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
`endif
        end

        DRAIN: begin
          // GAP cycles with in_ready low, the first one being the finish cycle.
          if (gap_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_frame_sequencer.sv
// Self-checking bench for range_frame_sequencer: a table-driven basic frame, directed
// corner sequences and a randomized run against a frame-level reference model.
module tb_range_frame_sequencer;

  localparam int WIDTH     = 12;
  localparam int FRAME_LEN = 16;
  localparam int GAP       = 4;
  localparam int TIMEOUT   = 64;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic [7:0]       frame_count;
  logic             truncated;

  range_frame_sequencer #(
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN),
    .GAP      (GAP),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .go         (go),
    .finish     (finish),
    .frame_count(frame_count),
    .truncated  (truncated)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts accepted samples in the current frame, the
  // blocked cycles still owed after a frame, and idle cycles since a sample.
  int               m_count;
  int               m_gap_left;
  int               m_idle;
  int               m_frames;
  logic [WIDTH-1:0] m_data;
  logic             m_go;
  logic             m_finish;
  logic             m_trunc;
  logic             last_xfer;

  task automatic model_reset();
    m_count    = 0;
    m_gap_left = 0;
    m_idle     = 0;
    m_frames   = 0;
    m_data     = '0;
    m_go       = 1'b0;
    m_finish   = 1'b0;
    m_trunc    = 1'b0;
    last_xfer  = 1'b0;
  endtask

  task automatic model_end_frame(input logic trunc);
    m_finish   = 1'b1;
    m_trunc    = trunc;
    m_frames   = m_frames + 1;
    m_count    = 0;
    m_idle     = 0;
    m_gap_left = GAP;
  endtask

  task automatic model_step(input logic x, input logic [WIDTH-1:0] d);
    m_go     = 1'b0;
    m_finish = 1'b0;
    m_trunc  = 1'b0;
    if (m_gap_left > 0) begin
      m_gap_left = m_gap_left - 1;
    end else if (x) begin
      m_data  = d;
      m_count = m_count + 1;
      m_idle  = 0;
      if (m_count == 1) m_go = 1'b1;
      if (m_count == FRAME_LEN) model_end_frame(1'b0);
    end else if (m_count > 0) begin
      m_idle = m_idle + 1;
`ifdef RFS_TIMEOUT_EN
      if (m_idle == TIMEOUT) model_end_frame(1'b1);
`endif
    end
  endtask

  task automatic compare_all();
    check("in_ready", 32'(in_ready), 32'(m_gap_left == 0));
    check("go", 32'(go), 32'(m_go));
    check("finish", 32'(finish), 32'(m_finish));
    check("truncated", 32'(truncated), 32'(m_trunc));
    check("data_out", 32'(data_out), 32'(m_data));
    check("frame_count", 32'(frame_count), 32'(m_frames % 256));
  endtask

  // Called at a falling edge: drive inputs, advance the model over the next
  // rising edge, then compare at the following falling edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d);
    in_valid  = v;
    in_data   = d;
    last_xfer = v && (m_gap_left == 0);
    model_step(last_xfer, d);
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_go"}, 32'(go), 32'd0);
    check({tag, "_finish"}, 32'(finish), 32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    check({tag, "_truncated"}, 32'(truncated), 32'd0);
  endtask

  // Asserts reset at a falling edge, checks outputs cleared at once, and
  // releases it at the next falling edge.
  task automatic apply_reset(input string tag);
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             exp_ready;
    logic             exp_go;
    logic             exp_finish;
    logic [WIDTH-1:0] exp_data;
    logic [7:0]       exp_frames;
  } vec_t;

  localparam int NVEC = FRAME_LEN + GAP + 2;
  vec_t vecs[NVEC];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] stall_samples[FRAME_LEN];
    logic             pv;
    logic [WIDTH-1:0] pd;
    int               k;
    int               low_cnt;
    int               go2_seen;
    logic [WIDTH-1:0] go2_data;
    int               n;
    int               found;

    // Basic frame 0x010..0x01F, expectations written straight from the timing rules.
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].valid      = (i < FRAME_LEN);
      vecs[i].data       = (i < FRAME_LEN) ? 12'(12'h010 + i) : 12'h000;
      vecs[i].exp_data   = (i < FRAME_LEN) ? 12'(12'h010 + i) : 12'h01F;
      vecs[i].exp_go     = (i == 0);
      vecs[i].exp_finish = (i == FRAME_LEN - 1);
      vecs[i].exp_ready  = !(i >= FRAME_LEN - 1 && i < FRAME_LEN - 1 + GAP);
      vecs[i].exp_frames = (i >= FRAME_LEN - 1) ? 8'd1 : 8'd0;
    end

    repeat (2) @(negedge clock);
    #1;
    check_reset_values("por");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      @(posedge clock);
      @(negedge clock);
      check("vec_in_ready", 32'(in_ready), 32'(vecs[i].exp_ready));
      check("vec_go", 32'(go), 32'(vecs[i].exp_go));
      check("vec_finish", 32'(finish), 32'(vecs[i].exp_finish));
      check("vec_data_out", 32'(data_out), 32'(vecs[i].exp_data));
      check("vec_frame_count", 32'(frame_count), 32'(vecs[i].exp_frames));
    end

    // Stalled frame: five idle cycles after the third sample.
    apply_reset("rst_stall");
    stall_samples[0] = 12'h800;
    stall_samples[1] = 12'h005;
    stall_samples[2] = 12'hFFF;
    for (int i = 3; i < FRAME_LEN; i++) stall_samples[i] = 12'($urandom);
    for (int i = 0; i < 3; i++) cycle(1'b1, stall_samples[i]);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 12'($urandom));
      check("stall_hold", 32'(data_out), 32'h0FFF);
      check("stall_no_pulse", 32'({go, finish}), 32'd0);
    end
    for (int i = 3; i < FRAME_LEN; i++) cycle(1'b1, stall_samples[i]);
    check("stall_finish", 32'(finish), 32'd1);
    check("stall_last", 32'(data_out), 32'(stall_samples[FRAME_LEN-1]));
    repeat (GAP) cycle(1'b0, '0);

    // Backpressure: in_valid held high across two frames.
    apply_reset("rst_bp");
    k        = 0;
    low_cnt  = 0;
    go2_seen = 0;
    go2_data = '0;
    for (int i = 0; i < 80 && k < 2 * FRAME_LEN; i++) begin
      cycle(1'b1, 12'(12'h100 + k));
      if (last_xfer) k++;
      if (m_frames == 1 && !in_ready) low_cnt++;
      if (go && m_frames == 1) begin
        go2_seen++;
        go2_data = data_out;
      end
    end
    check("bp_samples", 32'(k), 32'(2 * FRAME_LEN));
    check("bp_gap_cycles", 32'(low_cnt), 32'(GAP));
    check("bp_go2_seen", 32'(go2_seen), 32'd1);
    check("bp_go2_data", 32'(go2_data), 32'(12'h100 + FRAME_LEN));
    repeat (GAP) cycle(1'b0, '0);

    // Wrap: 256 frames with in_valid continuously high.
    apply_reset("rst_wrap");
    for (int f = 0; f < 256; f++) begin
      for (int j = 0; j < FRAME_LEN + GAP; j++) cycle(1'b1, 12'($urandom));
      if (f == 254) check("wrap_255", 32'(frame_count), 32'd255);
    end
    check("wrap_0", 32'(frame_count), 32'd0);

    // Mid-frame reset after the seventh sample.
    for (int i = 0; i < 7; i++) cycle(1'b1, 12'($urandom));
    apply_reset("rst_mid");
    cycle(1'b1, 12'hABC);
    check("mid_go", 32'(go), 32'd1);
    check("mid_data", 32'(data_out), 32'h0ABC);
    for (int i = 1; i < FRAME_LEN; i++) cycle(1'b1, 12'($urandom));
    repeat (GAP) cycle(1'b0, '0);

    // Stall after sample 5 (0x123).
    apply_reset("rst_to");
    for (int i = 0; i < 4; i++) cycle(1'b1, 12'($urandom));
    cycle(1'b1, 12'h123);
    n     = 0;
    found = 0;
`ifdef RFS_TIMEOUT_EN
    for (int i = 0; i < 200 && found == 0; i++) begin
      cycle(1'b0, '0);
      n++;
      if (finish) found = 1;
    end
    check("to_finish_seen", 32'(found), 32'd1);
    check("to_delay", 32'(n), 32'(TIMEOUT));
    check("to_truncated", 32'(truncated), 32'd1);
    check("to_data", 32'(data_out), 32'h0123);
    check("to_frames", 32'(frame_count), 32'd1);
    repeat (GAP) cycle(1'b0, '0);
`else
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b0, '0);
      if (finish) found++;
    end
    check("no_to_finish", 32'(found), 32'd0);
    check("no_to_frames", 32'(frame_count), 32'd0);
    check("no_to_ready", 32'(in_ready), 32'd1);
`endif

    // Randomized traffic with a source that holds its sample until accepted.
    apply_reset("rst_rand");
    pv = 1'b0;
    pd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 99) < 70);
        pd = 12'($urandom);
      end
      cycle(pv, pd);
      if (last_xfer) pv = 1'b0;
      if (i % 700 == 350 && !pv) begin
        repeat (TIMEOUT + 6) cycle(1'b0, 12'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_frame_sequencer.md
# range_frame_sequencer

Upstream framing stage for the range finder. It accepts a valid/ready sample stream, registers each sample, and chops the stream into fixed-length frames. For every frame it drives the range finder's `data_in`, `go` and `finish` inputs, so the range finder no longer runs with `go` and `finish` tied off. A mandatory idle gap after each frame gives the range finder time to publish its result.

## Interface
- `WIDTH`, 12: sample width in bits. Matches the range finder's `WIDTH`.
- `FRAME_LEN`, 16: samples per frame. Legal range 2..255.
- `GAP`, 4: idle cycles after `finish`. Legal range 1..15.
- `TIMEOUT`, 64: maximum stall between samples, in cycles. Used only with `RFS_TIMEOUT_EN`. Legal range 2..255.
- `clock`  input  1: single clock. All logic is on the rising edge.
- `reset`  input  1: asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to `clock`.
- `in_data`  input  WIDTH: sample value.
- `in_valid`  input  1: `in_data` is valid this cycle.
- `in_ready`  output  1: the block can accept a sample. A sample transfers when `in_valid && in_ready` at the rising edge.
- `data_out`  output  WIDTH: registered sample for the range finder's `data_in`.
- `go`  output  1: one-cycle pulse; `data_out` carries sample 1 of a frame.
- `finish`  output  1: one-cycle pulse; `data_out` carries the last sample of a frame.
- `frame_count`  output  8: number of completed frames, wraps 255→0.
- `truncated`  output  1: one-cycle pulse on a timeout-terminated frame.

## Operation
- Reset values:
  - `in_ready`=1, `data_out`=0, `go`=0, `finish`=0, `frame_count`=0, `truncated`=0.
  - State IDLE, sample counter 0.
- State IDLE:
  - `in_ready`=1.
  - On a transfer: `data_out`←`in_data`, `go`=1 next cycle, counter←1, go to RUN.
- State RUN:
  - `in_ready`=1.
  - Each transfer: `data_out`←`in_data`, counter+1.
  - On the transfer that makes counter equal `FRAME_LEN`: `finish`=1 next cycle, `frame_count`+1, counter←0, go to DRAIN.
- State DRAIN:
  - `in_ready`=0 for exactly `GAP` cycles, starting the cycle `finish` is high; then go to IDLE.
  - `in_valid` during DRAIN is not accepted. The source holds the sample per the handshake.
- Stalls (`in_valid`=0 in RUN): `data_out` holds the last accepted sample, and `go`/`finish` stay 0. Holding the value cannot change the frame's min or max.
- `go` and `finish` are never high in the same cycle, because `FRAME_LEN`≥2.
- `frame_count` wraps modulo 256 with no flag.
- Counter width is 8 bits; the sample counter never exceeds `FRAME_LEN`.
- Reset asserted mid-frame: the frame is discarded, no `finish` is produced, and all outputs return to reset values at once.

## Timing
- Latency is 1 cycle from transfer to `data_out`, and from the transfer to the corresponding `go` or `finish`.
- `go`, `finish`, `truncated` and `data_out` are all registered. `in_ready` is a function of state only and never combinationally depends on `in_valid`.
- Minimum frame period is `FRAME_LEN`+`GAP` cycles: `FRAME_LEN` cycles in IDLE/RUN plus `GAP` cycles in DRAIN.
- First transfer can occur the cycle after `reset` releases.

## Configuration
- `RFS_TIMEOUT_EN` defined:
  - In RUN, a stall counter resets on each transfer and increments on each cycle without one.
  - When the stall counter reaches `TIMEOUT`: `finish`=1 and `truncated`=1 the next cycle, with `data_out` still holding the last sample. `frame_count`+1, then go to DRAIN.
  - A transfer in the same cycle the stall counter would reach `TIMEOUT` takes priority: the sample is accepted and there is no timeout.
- `RFS_TIMEOUT_EN` undefined:
  - No stall counter exists; RUN waits indefinitely for samples.
  - `truncated` is tied to 0.

## Test plan
- Basic frame: reset release, then 16 back-to-back samples 0x010..0x01F with `FRAME_LEN`=16, `GAP`=4. Expect:
  - `go` one cycle after the first transfer, with `data_out`=0x010.
  - `finish` with `data_out`=0x01F.
  - `in_ready` low for 4 cycles, then `frame_count`=1.
- Stalled frame: insert 5 idle cycles after sample 3 of 0x800,0x005,0xFFF,... Expect `data_out` to hold 0xFFF throughout the stall, no extra `go`/`finish`, and `finish` only after sample 16.
- Backpressure: hold `in_valid`=1 continuously across two frames. Expect exactly `GAP` cycles with `in_ready`=0 between frames, no sample lost or duplicated, and the second frame's `go` carrying sample 17.
- Wrap: run 256 frames. Expect `frame_count` to go 255→0.
- Mid-frame reset: assert `reset`=0 after sample 7. Expect all outputs at reset values immediately, no `finish`, and the next transfer producing `go`.
- Timeout (with `RFS_TIMEOUT_EN`, `TIMEOUT`=64): stop after sample 5 (value 0x123). Expect `finish`=`truncated`=1 64 cycles later, `data_out`=0x123, `frame_count`+1. Without the macro, expect no `finish` after 1000 idle cycles.
